mtx_in_stg: RTL and testbench



---
 rtl/mtx_in_stg.sv | 149 ++++++++++++++
 tb/tb_mtx_in_stg.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_in_stg.sv
// mtx_in_stg: AHB bus-matrix input stage that holds an address phase the output stage cannot take yet.
// Define MTX_IN_STG_AUSER_EN to add the HAUSERS/auser_ip sideband and its AUSER_WIDTH parameter.
module mtx_in_stg #(
    parameter int ADDR_WIDTH  = 32
`ifdef MTX_IN_STG_AUSER_EN
   ,parameter int AUSER_WIDTH = 32
`endif
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HSELS,
    input  logic [ADDR_WIDTH-1:0]  HADDRS,
`ifdef MTX_IN_STG_AUSER_EN
    input  logic [AUSER_WIDTH-1:0] HAUSERS,
`endif
    input  logic [1:0]             HTRANSS,
    input  logic                   HWRITES,
    input  logic [2:0]             HSIZES,
    input  logic [2:0]             HBURSTS,
    input  logic [3:0]             HPROTS,
    input  logic [3:0]             HMASTERS,
    input  logic                   HMASTLOCKS,
    input  logic                   HREADYS,
    input  logic                   active_ip,
    input  logic                   readyout_ip,
    input  logic                   resp_ip,
    output logic                   sel_ip,
    output logic [ADDR_WIDTH-1:0]  addr_ip,
`ifdef MTX_IN_STG_AUSER_EN
    output logic [AUSER_WIDTH-1:0] auser_ip,
`endif
    output logic [1:0]             trans_ip,
    output logic                   write_ip,
    output logic [2:0]             size_ip,
    output logic [2:0]             burst_ip,
    output logic [3:0]             prot_ip,
    output logic [3:0]             master_ip,
    output logic                   mastlock_ip,
    output logic                   held_tran_ip,
    output logic                   HREADYOUTS,
    output logic                   HRESPS
);

    typedef struct packed {
        logic                   sel;
        logic [ADDR_WIDTH-1:0]  addr;
`ifdef MTX_IN_STG_AUSER_EN
        logic [AUSER_WIDTH-1:0] auser;
`endif
        logic [1:0]             trans;
        logic                   write;
        logic [2:0]             size;
        logic [2:0]             burst;
        logic [3:0]             prot;
        logic [3:0]             master;
        logic                   mastlock;
    } addr_phase_t;

    addr_phase_t live_ap;
    addr_phase_t held_ap;
    addr_phase_t out_ap;

    logic held_valid;
    logic held_valid_nxt;
    logic data_phase;
    logic data_phase_nxt;
    logic capture;
    logic new_tran;
    logic accept;

    always_comb begin
        live_ap.sel      = HSELS;
        live_ap.addr     = HADDRS;
`ifdef MTX_IN_STG_AUSER_EN
        live_ap.auser    = HAUSERS;
`endif
        live_ap.trans    = HTRANSS;
        live_ap.write    = HWRITES;
        live_ap.size     = HSIZES;
        live_ap.burst    = HBURSTS;
        live_ap.prot     = HPROTS;
        live_ap.master   = HMASTERS;
        live_ap.mastlock = HMASTLOCKS;
    end

    // Every selected, ready cycle is captured (IDLE/BUSY too); only NONSEQ/SEQ become requests.
    assign capture      = HSELS & HREADYS;
    assign new_tran     = capture & HTRANSS[1];
    assign held_tran_ip = held_valid | new_tran;
    assign accept       = held_tran_ip & active_ip & readyout_ip;

    // NOTE: the holding register is reset too, so the bundle is never X after reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            held_ap <= '0;
        end else if (capture) begin
            held_ap <= live_ap;
        end
    end

    // NOTE: defaults first, then overrides; no path leaves a variable unassigned, so no latch.
    always_comb begin
        held_valid_nxt = held_valid;
        if (held_valid && accept) begin
            held_valid_nxt = 1'b0;
        end
        if (new_tran && !accept) begin
            held_valid_nxt = 1'b1;
        end

        data_phase_nxt = data_phase;
        if (readyout_ip && !accept) begin
            data_phase_nxt = 1'b0;
        end
        if (accept) begin
            data_phase_nxt = 1'b1;
        end
    end

    // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            held_valid <= 1'b0;
            data_phase <= 1'b0;
        end else begin
            held_valid <= held_valid_nxt;
            data_phase <= data_phase_nxt;
        end
    end

    assign out_ap      = held_valid ? held_ap : live_ap;
    assign sel_ip      = out_ap.sel;
    assign addr_ip     = out_ap.addr;
`ifdef MTX_IN_STG_AUSER_EN
    assign auser_ip    = out_ap.auser;
`endif
    assign trans_ip    = out_ap.trans;
    assign write_ip    = out_ap.write;
    assign size_ip     = out_ap.size;
    assign burst_ip    = out_ap.burst;
    assign prot_ip     = out_ap.prot;
    assign master_ip   = out_ap.master;
    assign mastlock_ip = out_ap.mastlock;

    // A held request stalls the master; otherwise the open data phase forwards the slave's ready.
    assign HREADYOUTS = held_valid ? 1'b0 : (data_phase ? readyout_ip : 1'b1);
    assign HRESPS     = data_phase ? resp_ip : 1'b0;

endmodule

// File: tb/tb_mtx_in_stg.sv
// tb_mtx_in_stg: directed scenarios plus randomized traffic against a transaction-level model of mtx_in_stg.
// The model keeps pending address phases in a queue and tracks whether a data phase is open.
module tb_mtx_in_stg;

    localparam int AW = 32;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    typedef logic [50:0] ap_t;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSELS;
    logic [AW-1:0] HADDRS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [3:0]    HPROTS;
    logic [3:0]    HMASTERS;
    logic          HMASTLOCKS;
    logic          HREADYS;
    logic          active_ip;
    logic          readyout_ip;
    logic          resp_ip;
    logic          sel_ip;
    logic [AW-1:0] addr_ip;
    logic [1:0]    trans_ip;
    logic          write_ip;
    logic [2:0]    size_ip;
    logic [2:0]    burst_ip;
    logic [3:0]    prot_ip;
    logic [3:0]    master_ip;
    logic          mastlock_ip;
    logic          held_tran_ip;
    logic          HREADYOUTS;
    logic          HRESPS;

    mtx_in_stg #(.ADDR_WIDTH(AW)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSELS       (HSELS),
        .HADDRS      (HADDRS),
        .HTRANSS     (HTRANSS),
        .HWRITES     (HWRITES),
        .HSIZES      (HSIZES),
        .HBURSTS     (HBURSTS),
        .HPROTS      (HPROTS),
        .HMASTERS    (HMASTERS),
        .HMASTLOCKS  (HMASTLOCKS),
        .HREADYS     (HREADYS),
        .active_ip   (active_ip),
        .readyout_ip (readyout_ip),
        .resp_ip     (resp_ip),
        .sel_ip      (sel_ip),
        .addr_ip     (addr_ip),
        .trans_ip    (trans_ip),
        .write_ip    (write_ip),
        .size_ip     (size_ip),
        .burst_ip    (burst_ip),
        .prot_ip     (prot_ip),
        .master_ip   (master_ip),
        .mastlock_ip (mastlock_ip),
        .held_tran_ip(held_tran_ip),
        .HREADYOUTS  (HREADYOUTS),
        .HRESPS      (HRESPS)
    );

    always #5 HCLK = ~HCLK;

    int   n_checks = 0;
    int   n_pass   = 0;
    ap_t  pend_q[$];
    bit   in_dp;
    logic exp_rdy, exp_new, exp_held_tran, exp_resp, exp_accept;
    ap_t  exp_bus;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic ap_t live_ap();
        return {HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS};
    endfunction

    function automatic ap_t dut_ap();
        return {sel_ip, addr_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip, master_ip, mastlock_ip};
    endfunction

    task automatic model_reset();
        pend_q.delete();
        in_dp = 1'b0;
    endtask

    task automatic drive(input logic sel, input logic [AW-1:0] addr, input logic [1:0] trans);
        HSELS      = sel;
        HADDRS     = addr;
        HTRANSS    = trans;
        HWRITES    = 1'($urandom_range(0, 1));
        HSIZES     = 3'($urandom_range(0, 7));
        HBURSTS    = 3'($urandom_range(0, 7));
        HPROTS     = 4'($urandom_range(0, 15));
        HMASTERS   = 4'($urandom_range(0, 15));
        HMASTLOCKS = 1'($urandom_range(0, 1));
    endtask

    // Called at posedge+1 with inputs applied: predicts outputs, closes the bus HREADY loop, checks mid-cycle.
    task automatic settle();
        exp_rdy       = (pend_q.size() != 0) ? 1'b0 : (in_dp ? readyout_ip : 1'b1);
        HREADYS       = exp_rdy;
        exp_new       = HSELS & exp_rdy & HTRANSS[1];
        exp_held_tran = (pend_q.size() != 0) | exp_new;
        exp_bus       = (pend_q.size() != 0) ? pend_q[0] : live_ap();
        exp_resp      = in_dp ? resp_ip : 1'b0;
        exp_accept    = exp_held_tran & active_ip & readyout_ip;
        #4;
        check("held_tran", 64'(held_tran_ip), 64'(exp_held_tran));
        check("bundle",    64'(dut_ap()),     64'(exp_bus));
        check("hreadyout", 64'(HREADYOUTS),   64'(exp_rdy));
        check("hresp",     64'(HRESPS),       64'(exp_resp));
    endtask

    task automatic tick();
        @(posedge HCLK);
        if (exp_accept) begin
            if (pend_q.size() != 0) void'(pend_q.pop_front());
            in_dp = 1'b1;
        end else begin
            if (exp_new) pend_q.push_back(live_ap());
            if (readyout_ip) in_dp = 1'b0;
        end
        #1;
    endtask

    int stall;

    initial begin
        HRESETn     = 1'b0;
        HREADYS     = 1'b1;
        active_ip   = 1'b0;
        readyout_ip = 1'b1;
        resp_ip     = 1'b0;
        drive(1'b0, '0, IDLE);
        model_reset();

        // Reset state
        #2;
        check("rst_ready", 64'(HREADYOUTS),   64'd1);
        check("rst_resp",  64'(HRESPS),       64'd0);
        check("rst_req",   64'(held_tran_ip), 64'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Grant immediately
        drive(1'b1, 32'h0000_1000, NONSEQ);
        active_ip = 1'b1; readyout_ip = 1'b1; resp_ip = 1'b0;
        settle();
        check("imm_addr", 64'(addr_ip),      64'h1000);
        check("imm_req",  64'(held_tran_ip), 64'd1);
        tick();
        drive(1'b1, 32'h0000_1004, IDLE);
        settle();
        check("imm_dp_ready", 64'(HREADYOUTS), 64'd1);
        tick();

        // Grant delayed: captured, then held for four stalled cycles while the master wiggles
        drive(1'b1, 32'h0000_2000, NONSEQ);
        active_ip = 1'b0;
        settle();
        check("dly_capture_ready", 64'(HREADYOUTS), 64'd1);
        tick();
        stall = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_DEAD, NONSEQ);
            active_ip = (i == 3);
            settle();
            check("dly_addr",  64'(addr_ip),  64'h2000);
            check("dly_trans", 64'(trans_ip), 64'(NONSEQ));
            if (HREADYOUTS == 1'b0) stall++;
            tick();
        end
        check("dly_stall_cycles", 64'(stall), 64'd4);
        drive(1'b1, 32'h0000_2004, IDLE);
        settle();
        check("dly_dp_ready", 64'(HREADYOUTS), 64'd1);
        tick();

        // Wait-state slave: two low-ready data-phase cycles
        drive(1'b1, 32'h0000_3000, NONSEQ);
        active_ip = 1'b1; readyout_ip = 1'b1;
        settle();
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_3004, IDLE);
            readyout_ip = (i == 2);
            settle();
            check("ws_ready", 64'(HREADYOUTS), 64'(i == 2));
            tick();
        end

        // Two-cycle ERROR response; master drops to IDLE in the second cycle
        drive(1'b1, 32'h0000_4000, NONSEQ);
        readyout_ip = 1'b1; resp_ip = 1'b0;
        settle();
        tick();
        drive(1'b1, 32'h0000_4004, NONSEQ);
        readyout_ip = 1'b0; resp_ip = 1'b1;
        settle();
        check("err1_resp",  64'(HRESPS),     64'd1);
        check("err1_ready", 64'(HREADYOUTS), 64'd0);
        tick();
        drive(1'b1, 32'h0000_4004, IDLE);
        readyout_ip = 1'b1; resp_ip = 1'b1;
        settle();
        check("err2_resp",  64'(HRESPS),       64'd1);
        check("err2_ready", 64'(HREADYOUTS),   64'd1);
        check("err2_req",   64'(held_tran_ip), 64'd0);
        tick();
        drive(1'b0, '0, IDLE);
        resp_ip = 1'b0;
        settle();
        check("err_done_resp", 64'(HRESPS), 64'd0);
        tick();

        // Asynchronous reset while a transfer is held
        drive(1'b1, 32'h0000_5000, NONSEQ);
        active_ip = 1'b0; readyout_ip = 1'b1;
        settle();
        tick();
        settle();
        check("hold_pre_rst", 64'(HREADYOUTS), 64'd0);
        HRESETn = 1'b0;
        #1;
        check("mid_rst_req",   64'(held_tran_ip), 64'd0);
        check("mid_rst_ready", 64'(HREADYOUTS),   64'd1);
        check("mid_rst_resp",  64'(HRESPS),       64'd0);
        model_reset();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            drive(1'($urandom_range(0, 7) != 0), AW'($urandom), 2'($urandom_range(0, 3)));
            active_ip   = 1'($urandom_range(0, 2) != 0);
            readyout_ip = 1'($urandom_range(0, 3) != 0);
            resp_ip     = 1'($urandom_range(0, 7) == 0);
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
